// File: rtl/tomasulo_pkg.sv
// Shared types and default latencies for the back-end issue cluster.
package tomasulo_pkg;

  // CDB source encoding, also the value driven on cdb_src
  typedef enum logic [1:0] {
    CDB_INT = 2'd0,
    CDB_LS  = 2'd1,
    CDB_MUL = 2'd2,
    CDB_DIV = 2'd3
  } cdb_src_e;

  localparam int MUL_LATENCY  = 4;
  localparam int DIV_LATENCY  = 7;
  localparam int CDB_SR_DEPTH = 8;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. A lone requester always wins; on a
// tie the requester that was not granted most recently wins.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,     // slot available this cycle
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // 0: req[0] won last, 1: req[1] won last
  logic rr_last;

  // grant selection; nothing granted while the shared slot is taken
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = rr_last ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // fairness state moves only when someone actually wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rr_last <= 1'b0;
    else if (|gnt) rr_last <= gnt[1];
  end

endmodule

// File: rtl/cdb_slot_scheduler.sv
// CDB slot scheduler: books writeback slots for the fixed-latency MUL/DIV
// units at issue time and lets INT/LS use slot 0 only when it is free, so
// no two units ever drive the CDB in the same cycle.
module cdb_slot_scheduler
  import tomasulo_pkg::*;
#(
  parameter int MUL_LAT  = MUL_LATENCY,
  parameter int DIV_LAT  = DIV_LATENCY,
  parameter int SR_DEPTH = CDB_SR_DEPTH
) (
  input  logic                clk,
  input  logic                rst,        // async, active low
  input  logic                int_ready,
  input  logic                ls_ready,
  input  logic                mul_ready,
  input  logic                div_ready,
  input  logic                div_busy,
  output logic                int_issue,
  output logic                ls_issue,
  output logic                mul_issue,
  output logic                div_issue,
  output logic                cdb_valid,
  output logic [1:0]          cdb_src,
  output logic [SR_DEPTH-1:0] slot_busy
);

  // Illegal latency configurations would let bookings collide or fall off
  // the end of the register.
  generate
    if (MUL_LAT == DIV_LAT || MUL_LAT < 1 || DIV_LAT < 1 ||
        MUL_LAT >= SR_DEPTH || DIV_LAT >= SR_DEPTH) begin : g_bad_cfg
      $fatal(1, "cdb_slot_scheduler: illegal MUL_LAT/DIV_LAT/SR_DEPTH");
    end
  endgenerate

  // rsv[k]: CDB booked k cycles from now; src[k]: who booked it
  logic [SR_DEPTH-1:0]      rsv, rsv_n;
  logic [SR_DEPTH-1:0][1:0] src, src_n;
  logic [1:0]               il_gnt;

  // INT and LS share slot 0 with fair tie-breaking; also masked in reset
  rr_arb2 u_il_arb (
    .clk   (clk),
    .rst_n (rst),
    .en    (rst & ~rsv[0]),
    .req   ({ls_ready, int_ready}),
    .gnt   (il_gnt)
  );

  assign int_issue = il_gnt[0];
  assign ls_issue  = il_gnt[1];

  // MUL/DIV check the slot they will occupy once their latency elapses
  assign mul_issue = rst & mul_ready & ~rsv[MUL_LAT];
  assign div_issue = rst & div_ready & ~div_busy & ~rsv[DIV_LAT];

  // advance bookings one slot and add this cycle's MUL/DIV reservations
  always_comb begin
    rsv_n = {1'b0, rsv[SR_DEPTH-1:1]};
    src_n = '0;
    for (int k = 0; k < SR_DEPTH-1; k++) src_n[k] = src[k+1];
    if (mul_issue) begin
      rsv_n[MUL_LAT-1] = 1'b1;
      src_n[MUL_LAT-1] = CDB_MUL;
    end
    if (div_issue) begin
      rsv_n[DIV_LAT-1] = 1'b1;
      src_n[DIV_LAT-1] = CDB_DIV;
    end
  end

  // reservation register; reset drops in-flight bookings
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsv <= '0;
      src <= '0;
    end else begin
      rsv <= rsv_n;
      src <= src_n;
    end
  end

  // CDB select: a due booking owns the bus, otherwise the INT/LS winner
  always_comb begin
    cdb_valid = rsv[0] | int_issue | ls_issue;
    cdb_src   = CDB_INT;
    if (rsv[0])        cdb_src = src[0];
    else if (ls_issue) cdb_src = CDB_LS;
  end

  assign slot_busy = rsv;

endmodule

// File: tb/tb_cdb_slot_scheduler.sv
// Directed bench for cdb_slot_scheduler with default latencies (MUL 4, DIV 7).
module tb_cdb_slot_scheduler;
  import tomasulo_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       int_ready = 1'b0, ls_ready = 1'b0, mul_ready = 1'b0;
  logic       div_ready = 1'b0, div_busy = 1'b0;
  logic       int_issue, ls_issue, mul_issue, div_issue, cdb_valid;
  logic [1:0] cdb_src;
  logic [7:0] slot_busy;

  int checks = 0;
  int errors = 0;

  cdb_slot_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .int_ready (int_ready),
    .ls_ready  (ls_ready),
    .mul_ready (mul_ready),
    .div_ready (div_ready),
    .div_busy  (div_busy),
    .int_issue (int_issue),
    .ls_issue  (ls_issue),
    .mul_issue (mul_issue),
    .div_issue (div_issue),
    .cdb_valid (cdb_valid),
    .cdb_src   (cdb_src),
    .slot_busy (slot_busy)
  );

  always #5 clk = ~clk;

  logic [3:0] gnts;
  assign gnts = {div_issue, mul_issue, ls_issue, int_issue};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // no grant may target an already booked slot, and INT/LS never both win
  logic collide;
  assign collide = (int_issue & ls_issue) |
                   ((int_issue | ls_issue) & slot_busy[0]) |
                   (mul_issue & slot_busy[MUL_LATENCY]) |
                   (div_issue & slot_busy[DIV_LATENCY]);

  always @(negedge clk) begin
    if (rst) chk("no_collide", {31'd0, collide}, 32'd0);
  end

  initial begin
    // reset: grants forced off even with requests present
    int_ready = 1'b1; mul_ready = 1'b1;
    #3;
    chk("rst_gnts", {28'd0, gnts}, 32'd0);
    chk("rst_cdb_valid", {31'd0, cdb_valid}, 32'd0);
    chk("rst_cdb_src", {30'd0, cdb_src}, 32'd0);
    chk("rst_slot_busy", {24'd0, slot_busy}, 32'd0);
    int_ready = 1'b0; mul_ready = 1'b0;
    cyc();
    rst = 1'b1;

    // idle
    for (int c = 0; c < 10; c++) begin
      cyc();
      chk("idle_gnts", {28'd0, gnts}, 32'd0);
      chk("idle_cdb_valid", {31'd0, cdb_valid}, 32'd0);
      chk("idle_slot_busy", {24'd0, slot_busy}, 32'd0);
    end

    // single MUL: result on CDB 4 cycles later
    cyc();
    mul_ready = 1'b1; #1;
    chk("mul_issue_c0", {31'd0, mul_issue}, 32'd1);
    chk("mul_c0_cdb_valid", {31'd0, cdb_valid}, 32'd0);
    for (int c = 1; c <= 5; c++) begin
      cyc();
      mul_ready = 1'b0; #1;
      if (c == 1) chk("mul_slot_busy_c1", {24'd0, slot_busy}, 32'h08);
      chk("mul_cdb_valid", {31'd0, cdb_valid}, (c == 4) ? 32'd1 : 32'd0);
      if (c == 4) chk("mul_cdb_src", {30'd0, cdb_src}, 32'd2);
    end

    // DIV then MUL colliding on the same writeback slot
    cyc();
    div_ready = 1'b1; #1;
    chk("div_issue_c0", {31'd0, div_issue}, 32'd1);
    for (int c = 1; c <= 9; c++) begin
      cyc();
      div_ready = 1'b0;
      mul_ready = (c == 3 || c == 4); #1;
      if (c == 3) begin
        chk("mul_blocked_c3", {31'd0, mul_issue}, 32'd0);
        chk("div_slot_c3", {24'd0, slot_busy}, 32'h10);
      end
      if (c == 4) chk("mul_granted_c4", {31'd0, mul_issue}, 32'd1);
      chk("dm_cdb_valid", {31'd0, cdb_valid}, (c == 7 || c == 8) ? 32'd1 : 32'd0);
      if (c == 7) chk("div_cdb_src", {30'd0, cdb_src}, 32'd3);
      if (c == 8) chk("mul_cdb_src_c8", {30'd0, cdb_src}, 32'd2);
    end

    // LS alone wins, leaving LS as last winner
    cyc();
    mul_ready = 1'b0; ls_ready = 1'b1; #1;
    chk("ls_only", {30'd0, ls_issue, int_issue}, 32'd2);
    chk("ls_only_src", {30'd0, cdb_src}, 32'd1);
    chk("ls_only_valid", {31'd0, cdb_valid}, 32'd1);

    // both INT and LS ready: strict alternation starting with INT
    for (int c = 0; c < 6; c++) begin
      cyc();
      int_ready = 1'b1; ls_ready = 1'b1; #1;
      chk("rr_gnt", {30'd0, ls_issue, int_issue}, (c % 2) ? 32'd2 : 32'd1);
      chk("rr_src", {30'd0, cdb_src}, (c % 2) ? 32'd1 : 32'd0);
    end
    cyc();
    int_ready = 1'b0; ls_ready = 1'b0;

    // INT held while a MUL booking takes slot 0 at cycle 4
    cyc();
    int_ready = 1'b1; mul_ready = 1'b1; #1;
    chk("int_mul_c0", {28'd0, gnts}, 32'b0101);
    chk("int_mul_c0_src", {30'd0, cdb_src}, 32'd0);
    for (int c = 1; c <= 6; c++) begin
      cyc();
      mul_ready = 1'b0; #1;
      chk("int_held_issue", {31'd0, int_issue}, (c == 4) ? 32'd0 : 32'd1);
      chk("int_held_src", {30'd0, cdb_src}, (c == 4) ? 32'd2 : 32'd0);
      chk("int_held_valid", {31'd0, cdb_valid}, 32'd1);
    end
    cyc();
    int_ready = 1'b0;

    // divider busy, MUL booked, then reset mid-booking
    cyc();
    div_busy = 1'b1; div_ready = 1'b1; mul_ready = 1'b1; #1;
    chk("busy_div_c0", {31'd0, div_issue}, 32'd0);
    chk("busy_mul_c0", {31'd0, mul_issue}, 32'd1);
    cyc();
    mul_ready = 1'b0; #1;
    chk("busy_div_c1", {31'd0, div_issue}, 32'd0);
    chk("busy_slot_c1", {24'd0, slot_busy}, 32'h08);
    cyc(); #1;
    chk("busy_div_c2", {31'd0, div_issue}, 32'd0);
    chk("busy_slot_c2", {24'd0, slot_busy}, 32'h04);
    rst = 1'b0; int_ready = 1'b1; #1;
    chk("midrst_slot", {24'd0, slot_busy}, 32'd0);
    chk("midrst_gnts", {28'd0, gnts}, 32'd0);
    chk("midrst_valid", {31'd0, cdb_valid}, 32'd0);
    cyc();
    rst = 1'b1; int_ready = 1'b0; div_busy = 1'b0; div_ready = 1'b0; #1;
    chk("postrst_slot", {24'd0, slot_busy}, 32'd0);
    cyc(); #1;
    chk("no_stale_cdb", {31'd0, cdb_valid}, 32'd0);
    chk("no_stale_slot", {24'd0, slot_busy}, 32'd0);

    // divider free again
    cyc();
    div_ready = 1'b1; #1;
    chk("div_after_busy", {31'd0, div_issue}, 32'd1);
    cyc();
    div_ready = 1'b0; #1;
    chk("div_booked", {24'd0, slot_busy}, 32'h40);

    // fairness state was cleared by reset: INT counts as last, LS wins tie
    cyc();
    int_ready = 1'b1; ls_ready = 1'b1; #1;
    chk("rr_after_rst", {30'd0, ls_issue, int_issue}, 32'd2);
    cyc();
    int_ready = 1'b0; ls_ready = 1'b0; #1;
    chk("rr_after_rst_idle", {30'd0, ls_issue, int_issue}, 32'd0);

    for (int c = 0; c < 10; c++) cyc();
    chk("drained", {24'd0, slot_busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
